// File: rtl/rv32i_mem_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
package rv32i_mem_pkg;

    localparam int          MASK_W    = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DATA  = 2'b01,
        ST_FETCH = 2'b10
    } arb_state_t;

    function automatic logic is_busy(input arb_state_t s);
        return (s == ST_DATA) || (s == ST_FETCH);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for a memory ack; expires on the TIMEOUT-th waiting cycle.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int             CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Wait counter: cleared on grant, saturates at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_en && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
        end
    end

    // r_cnt holds the number of completed wait cycles, so this edge would make it TIMEOUT.
    assign o_expire = i_en & (r_cnt == CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// with req/ack sequencing, pipeline stall generation and access timeout.
module mem_port_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [MASK_W-1:0] ls_mask,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MASK_W-1:0] mem_mask,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall,
    output logic              load_control,
    output logic              timeout_err
);
    localparam logic [DATA_W-1:0] NOP_WORD  = DATA_W'(NOP_INSTR);
    localparam logic [MASK_W-1:0] FULL_MASK = {MASK_W{1'b1}};

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_grant_ls;
    logic              w_grant_if;
    logic              w_ack_done;
    logic              w_to_done;
    logic              w_expire;
    logic              w_busy;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [MASK_W-1:0] r_mem_mask;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_ls_done;
    logic              r_timeout_err;

    assign w_busy = is_busy(r_state);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst),
        .i_clr    (w_grant_ls | w_grant_if),
        .i_en     (w_busy),
        .o_expire (w_expire)
    );

    // Next state: load/store wins over fetch; a requester is not re-granted during its own done pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_ls  = 1'b0;
        w_grant_if  = 1'b0;
        w_ack_done  = 1'b0;
        w_to_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ls_req && !r_ls_done) begin
                    w_grant_ls  = 1'b1;
                    w_state_nxt = ST_DATA;
                end else if (if_req && !r_if_valid) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA, ST_FETCH: begin
                if (mem_ack) begin
                    w_ack_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_to_done   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, memory-side request registers and requester return registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_mask    <= {MASK_W{1'b0}};
            r_mem_addr    <= {ADDR_W{1'b0}};
            r_mem_wdata   <= {DATA_W{1'b0}};
            r_if_rdata    <= {DATA_W{1'b0}};
            r_if_valid    <= 1'b0;
            r_ls_rdata    <= {DATA_W{1'b0}};
            r_ls_done     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_if_valid <= 1'b0;
            r_ls_done  <= 1'b0;
            if (w_grant_ls) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= ls_we;
                r_mem_mask  <= ls_mask;
                r_mem_addr  <= ls_addr;
                r_mem_wdata <= ls_wdata;
            end else if (w_grant_if) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_mask  <= FULL_MASK;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= {DATA_W{1'b0}};
            end
            // An aborted access still completes: fetch sees a NOP, load sees zero, store data is untouched.
            if (w_ack_done || w_to_done) begin
                r_mem_req <= 1'b0;
                if (r_state == ST_DATA) begin
                    r_ls_done <= 1'b1;
                    if (!r_mem_we) begin
                        r_ls_rdata <= w_ack_done ? mem_rdata : {DATA_W{1'b0}};
                    end
                end else begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= w_ack_done ? mem_rdata : NOP_WORD;
                end
            end
            if (w_to_done) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign mem_req      = r_mem_req;
    assign mem_we       = r_mem_we;
    assign mem_mask     = r_mem_mask;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign if_rdata     = r_if_rdata;
    assign if_valid     = r_if_valid;
    assign ls_rdata     = r_ls_rdata;
    assign ls_done      = r_ls_done;
    assign timeout_err  = r_timeout_err;
    assign load_control = (r_state == ST_DATA) & ~r_mem_we;
    assign stall        = (if_req & ~r_if_valid) | (ls_req & ~r_ls_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios pinned with literals, then random
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we, mem_ack;
    logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
    logic [3:0]  ls_mask;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_mask;
    logic        if_valid, ls_done, mem_req, mem_we, stall, load_control, timeout_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .ls_req(ls_req), .ls_we(ls_we), .ls_mask(ls_mask), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_mask(mem_mask), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .stall(stall), .load_control(load_control), .timeout_err(timeout_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding access at a time, described by who/what/how long.
    bit          m_busy, m_is_ls, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    int          m_waited, m_delay;
    logic        e_mem_req, e_if_valid, e_ls_done, e_timeout_err;
    logic [31:0] e_if_rdata, e_ls_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return TIMEOUT - 1;
        if (r == 1) return TIMEOUT + int'($urandom_range(0, 2));
        return int'($urandom_range(0, 4));
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_is_ls = 1'b0; m_we = 1'b0;
        m_addr = 32'h0; m_wdata = 32'h0; m_mask = 4'h0;
        m_waited = 0; m_delay = 0;
        e_mem_req = 1'b0; e_if_valid = 1'b0; e_ls_done = 1'b0; e_timeout_err = 1'b0;
        e_if_rdata = 32'h0; e_ls_rdata = 32'h0;
    endtask

    task automatic finish_access(input bit ok, input logic [31:0] data);
        m_busy = 1'b0;
        if (!ok) e_timeout_err = 1'b1;
        if (m_is_ls) begin
            e_ls_done = 1'b1;
            if (!m_we) e_ls_rdata = ok ? data : 32'h0;
        end else begin
            e_if_valid = 1'b1;
            e_if_rdata = ok ? data : 32'h0000_0013;
        end
    endtask

    // Advance the model across one clock edge using the inputs now being driven.
    task automatic model_step();
        logic old_iv, old_ld;
        old_iv = e_if_valid;
        old_ld = e_ls_done;
        if (!rst) begin
            model_reset();
            return;
        end
        e_if_valid = 1'b0;
        e_ls_done  = 1'b0;
        if (m_busy) begin
            if (mem_ack) begin
                finish_access(1'b1, mem_rdata);
            end else begin
                m_waited++;
                if (m_waited == TIMEOUT) finish_access(1'b0, 32'h0);
            end
        end else if (ls_req && !old_ld) begin
            m_busy = 1'b1; m_is_ls = 1'b1; m_we = ls_we;
            m_addr = ls_addr; m_mask = ls_mask; m_wdata = ls_wdata;
            m_waited = 0; m_delay = pick_delay();
        end else if (if_req && !old_iv) begin
            m_busy = 1'b1; m_is_ls = 1'b0; m_we = 1'b0;
            m_addr = if_addr; m_mask = 4'hF; m_wdata = 32'h0;
            m_waited = 0; m_delay = pick_delay();
        end
        e_mem_req = m_busy;
    endtask

    task automatic compare_all();
        chk("mem_req", 32'(mem_req), 32'(e_mem_req));
        chk("if_valid", 32'(if_valid), 32'(e_if_valid));
        chk("ls_done", 32'(ls_done), 32'(e_ls_done));
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("ls_rdata", ls_rdata, e_ls_rdata);
        chk("timeout_err", 32'(timeout_err), 32'(e_timeout_err));
        chk("load_control", 32'(load_control), 32'(m_busy && m_is_ls && !m_we));
        if (e_mem_req) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", 32'(mem_we), 32'(m_we));
            if (m_is_ls) begin
                chk("mem_mask", 32'(mem_mask), 32'(m_mask));
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
        end
    endtask

    // Called just after a falling edge with inputs already set; returns after the next falling edge.
    task automatic step();
        #1;
        chk("stall", 32'(stall), 32'((if_req & ~e_if_valid) | (ls_req & ~e_ls_done)));
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive_random();
        bit new_ls, new_if;
        new_ls = 1'b0;
        new_if = 1'b0;
        if (ls_req) begin
            if (e_ls_done) begin
                ls_req = 1'b0;
                new_ls = ($urandom_range(0, 3) == 0);
            end
        end else begin
            new_ls = ($urandom_range(0, 3) == 0);
        end
        if (new_ls) begin
            ls_req   = 1'b1;
            ls_we    = 1'($urandom_range(0, 1));
            ls_addr  = $urandom & 32'hFFFF_FFFC;
            ls_mask  = 4'($urandom_range(1, 15));
            ls_wdata = $urandom;
        end
        if (if_req) begin
            if (e_if_valid) begin
                if_req = 1'b0;
                new_if = ($urandom_range(0, 3) == 0);
            end
        end else begin
            new_if = ($urandom_range(0, 2) == 0);
        end
        if (new_if) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (m_busy) mem_ack = (m_waited == m_delay);
        else        mem_ack = ($urandom_range(0, 7) == 0);
        mem_rdata = $urandom;
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; mem_ack = 1'b0;
        if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; mem_rdata = 32'h0; ls_mask = 4'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_ls_done", 32'(ls_done), 32'h0);
        chk("rst_timeout_err", 32'(timeout_err), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        rst = 1'b1;

        // Fetch with ack three cycles after mem_req rises.
        if_req = 1'b1; if_addr = 32'h40;
        step();
        chk("t1_mem_req", 32'(mem_req), 32'h1);
        chk("t1_mem_addr", mem_addr, 32'h40);
        step(); step(); step();
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        step();
        chk("t1_if_valid", 32'(if_valid), 32'h1);
        chk("t1_if_rdata", if_rdata, 32'h0050_0093);
        chk("t1_stall", 32'(stall), 32'h0);
        mem_ack = 1'b0; if_req = 1'b0;
        step();

        // Simultaneous store and fetch: store first, fetch after one idle cycle.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_mask = 4'hF;
        if_req = 1'b1; if_addr = 32'h44;
        step();
        chk("t2_mem_we", 32'(mem_we), 32'h1);
        chk("t2_mem_addr", mem_addr, 32'h100);
        chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_ack = 1'b1;
        step();
        chk("t2_ls_done", 32'(ls_done), 32'h1);
        chk("t2_idle_gap", 32'(mem_req), 32'h0);
        chk("t2_stall_fetch", 32'(stall), 32'h1);
        ls_req = 1'b0; mem_ack = 1'b0;
        step();
        chk("t2_fetch_req", 32'(mem_req), 32'h1);
        chk("t2_fetch_addr", mem_addr, 32'h44);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0513;
        step();
        chk("t2_if_valid", 32'(if_valid), 32'h1);
        chk("t2_store_keeps_rdata", ls_rdata, 32'h0);
        mem_ack = 1'b0; if_req = 1'b0;
        step();

        // Load.
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_mask = 4'hF;
        step();
        chk("t3_load_control", 32'(load_control), 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step();
        chk("t3_ls_done", 32'(ls_done), 32'h1);
        chk("t3_ls_rdata", ls_rdata, 32'h1234_5678);
        chk("t3_load_control_off", 32'(load_control), 32'h0);
        ls_req = 1'b0; mem_ack = 1'b0;
        step();

        // Ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        chk("t6_if_valid", 32'(if_valid), 32'h0);
        chk("t6_ls_done", 32'(ls_done), 32'h0);
        chk("t6_mem_req", 32'(mem_req), 32'h0);
        chk("t6_ls_rdata", ls_rdata, 32'h1234_5678);
        mem_ack = 1'b0;

        // Fetch timeout: mem_req high for exactly TIMEOUT cycles.
        if_req = 1'b1; if_addr = 32'h80;
        step();
        chk("t4_mem_req_first", 32'(mem_req), 32'h1);
        repeat (TIMEOUT - 1) step();
        chk("t4_mem_req_last", 32'(mem_req), 32'h1);
        step();
        chk("t4_mem_req_drop", 32'(mem_req), 32'h0);
        chk("t4_if_valid", 32'(if_valid), 32'h1);
        chk("t4_if_rdata_nop", if_rdata, 32'h0000_0013);
        chk("t4_timeout_err", 32'(timeout_err), 32'h1);
        if_req = 1'b0;
        step(); step();
        chk("t4_timeout_sticky", 32'(timeout_err), 32'h1);

        // Reset mid-access, then the same request is served again.
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h300; ls_wdata = 32'hCAFE_F00D; ls_mask = 4'h3;
        step(); step();
        rst = 1'b0;
        #1;
        chk("t5_async_mem_req", 32'(mem_req), 32'h0);
        chk("t5_timeout_clr", 32'(timeout_err), 32'h0);
        model_reset();
        step();
        rst = 1'b1;
        step();
        chk("t5_regrant", 32'(mem_req), 32'h1);
        chk("t5_regrant_addr", mem_addr, 32'h300);
        mem_ack = 1'b1;
        step();
        chk("t5_ls_done", 32'(ls_done), 32'h1);
        ls_req = 1'b0; mem_ack = 1'b0;
        step();

        // Random traffic against the model.
        repeat (3000) begin
            drive_random();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
